// File: rtl/window_power_capture_if.sv
// Streaming sample / published-word bundle for window_power_capture.
// The slave modport is the capture block; the master modport is the feeder side.
interface window_power_capture_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned LEN_W  = 16
);
  logic signed [DATA_W-1:0] din_re;
  logic signed [DATA_W-1:0] din_im;
  logic                     din_valid;
  logic                     sync;
  logic [LEN_W-1:0]         win_len;
  logic [31:0]              user_data_out;
  logic                     dout_valid;
  logic                     sat;

  modport master (
    output din_re, din_im, din_valid, sync, win_len,
    input  user_data_out, dout_valid, sat
  );

  modport slave (
    input  din_re, din_im, din_valid, sync, win_len,
    output user_data_out, dout_valid, sat
  );
endinterface

// File: rtl/window_power_capture.sv
// Window power capture: accumulates |x|^2 over a programmable number of
// samples and publishes each window as a held 32-bit word plus a strobe.
// Optional macro WINDOW_POWER_CAPTURE_SEQ_TAG_EN: top byte carries an 8-bit
// window sequence number and the power field narrows to 24 bits.
module window_power_capture #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  window_power_capture_if.slave bus
);

  localparam int unsigned SQ_W  = 2 * DATA_W;
  localparam int unsigned P_W   = 2 * DATA_W + 1;
  localparam int unsigned ACC_W = P_W + LEN_W;
  localparam int unsigned CNT_W = LEN_W + 1;

`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(32'h00FF_FFFF);
`else
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(32'hFFFF_FFFF);
`endif

  // Stage 1: exact instantaneous power
  logic signed [SQ_W-1:0] re_sq;
  logic signed [SQ_W-1:0] im_sq;
  logic [P_W-1:0]         p_d;
  logic [P_W-1:0]         p1_q;
  logic                   v1_q;
  logic                   s1_q;

  assign re_sq = bus.din_re * bus.din_re;
  assign im_sq = bus.din_im * bus.din_im;
  assign p_d   = P_W'($unsigned(re_sq)) + P_W'($unsigned(im_sq));

  // Stage 1 register: power with its qualifier and restart flag
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      p1_q <= '0;
      v1_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      p1_q <= p_d;
      v1_q <= bus.din_valid;
      s1_q <= bus.sync;
    end
  end

  // Stage 2: accumulate and detect window close
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] win_q, win_d;
  logic             close2_q, close2_d;
  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_eff;

  // sync discards the partial window; a sample on the sync cycle opens the new one
  assign acc_base = s1_q ? '0 : acc_q;
  assign cnt_base = s1_q ? '0 : cnt_q;
  assign acc_sum  = acc_base + ACC_W'(p1_q);
  assign cnt_inc  = cnt_base + CNT_W'(1);
  assign len_eff  = (bus.win_len == '0) ? CNT_W'(1) : CNT_W'(bus.win_len);

  // Next accumulator/count; >= lets a shrunken win_len close at the next sample
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    close2_d = 1'b0;
    if (s1_q || v1_q) begin
      acc_d = acc_base;
      cnt_d = cnt_base;
      if (v1_q) begin
        if (cnt_inc >= len_eff) begin
          close2_d = 1'b1;
          win_d    = acc_sum;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
        end
      end
    end
  end

  // Stage 2 register: running window state and captured window total
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      close2_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      close2_q <= close2_d;
    end
  end

  // Stage 3: clamp the closed window to the published field width
  logic        sat3_d;
  logic [31:0] word3_d;
  logic        sat3_q;
  logic [31:0] word3_q;
  logic        close3_q;

  assign sat3_d  = (win_q > LIMIT);
  assign word3_d = sat3_d ? 32'(LIMIT) : 32'(win_q);

  // Stage 3 register: clamped word waiting for publication
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sat3_q   <= 1'b0;
      word3_q  <= '0;
      close3_q <= 1'b0;
    end else begin
      close3_q <= close2_q;
      if (close2_q) begin
        sat3_q  <= sat3_d;
        word3_q <= word3_d;
      end
    end
  end

  // Stage 4: published word, held until the next window closes
  logic [31:0] data_q;
  logic        dout_valid_q;
  logic        sat_q;

`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
  logic [7:0] seq_q;

  // Publish with the window's sequence tag; the tag advances per published window
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      data_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      seq_q        <= '0;
    end else begin
      dout_valid_q <= close3_q;
      if (close3_q) begin
        data_q <= {seq_q, word3_q[23:0]};
        sat_q  <= sat3_q;
        seq_q  <= seq_q + 8'd1;
      end
    end
  end
`else
  // Publish the full 32-bit clamped window power
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      data_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      dout_valid_q <= close3_q;
      if (close3_q) begin
        data_q <= word3_q;
        sat_q  <= sat3_q;
      end
    end
  end
`endif

  assign bus.user_data_out = data_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.sat           = sat_q;

endmodule

// File: tb/tb_window_power_capture.sv
// Bench for window_power_capture: sample-level window model, per-cycle compare,
// directed literal scenarios and a randomized phase.
module tb_window_power_capture;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned LEN_W  = 16;

  logic user_clk = 1'b0;
  logic user_rst_n;

  window_power_capture_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  window_power_capture #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .bus       (bus)
  );

  always #5 user_clk = ~user_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit          exp_v [65536];
  logic [31:0] exp_w [65536];
  bit          exp_s [65536];

  longint m_acc  = 0;
  int     m_cnt  = 0;
  int     m_seq  = 0;
  bit     pend_ok = 1'b0;
  bit     pend_v  = 1'b0;
  bit     pend_s  = 1'b0;
  longint pend_p  = 0;

  logic [31:0] held_w = '0;
  bit          held_s = 1'b0;

  int          pulse_cnt = 0;
  logic [31:0] last_w = '0;
  bit          last_s = 1'b0;
  int          pulse_q[$];

  function automatic int idx(int c);
    return c & 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] lo(logic [31:0] w);
`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
    return {8'h00, w[23:0]};
`else
    return w;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // Window model: a sample taken at edge k is judged against win_len at edge k+1
  // and its window, if closed, is published at edge k+3.
  always @(posedge user_clk) begin
    int          l_eff;
    longint      lim;
    logic [31:0] w;
    bit          s;
    cyc = cyc + 1;
    if (!user_rst_n) begin
      for (int k = 0; k < 3; k++) exp_v[idx(cyc + k)] = 1'b0;
      m_acc = 0;
      m_cnt = 0;
      m_seq = 0;
    end else begin
      exp_v[idx(cyc + 2)] = 1'b0;
      if (pend_ok) begin
        l_eff = (bus.win_len == '0) ? 1 : int'(bus.win_len);
        if (pend_s) begin
          m_acc = 0;
          m_cnt = 0;
        end
        if (pend_v) begin
          m_acc = m_acc + pend_p;
          m_cnt = m_cnt + 1;
          if (m_cnt >= l_eff) begin
`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
            lim = 64'h0000_0000_00FF_FFFF;
            s = (m_acc > lim);
            w = {m_seq[7:0], s ? 24'hFF_FFFF : m_acc[23:0]};
            m_seq = (m_seq + 1) % 256;
`else
            lim = 64'h0000_0000_FFFF_FFFF;
            s = (m_acc > lim);
            w = s ? 32'hFFFF_FFFF : m_acc[31:0];
`endif
            exp_v[idx(cyc + 2)] = 1'b1;
            exp_w[idx(cyc + 2)] = w;
            exp_s[idx(cyc + 2)] = s;
            m_acc = 0;
            m_cnt = 0;
          end
        end
      end
    end
    pend_ok = user_rst_n;
    pend_v  = bus.din_valid;
    pend_s  = bus.sync;
    pend_p  = longint'(bus.din_re) * longint'(bus.din_re)
            + longint'(bus.din_im) * longint'(bus.din_im);
  end

  // Per-cycle compare of all outputs against the model, plus pulse monitor
  always @(negedge user_clk) begin
    if (!user_rst_n) begin
      held_w = '0;
      held_s = 1'b0;
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_user_data_out", bus.user_data_out, 32'd0);
      chk("rst_sat", 32'(bus.sat), 32'd0);
    end else begin
      if (exp_v[idx(cyc)]) begin
        held_w = exp_w[idx(cyc)];
        held_s = exp_s[idx(cyc)];
      end
      chk("dout_valid", 32'(bus.dout_valid), 32'(exp_v[idx(cyc)]));
      chk("user_data_out", bus.user_data_out, held_w);
      chk("sat", 32'(bus.sat), 32'(held_s));
    end
    if (bus.dout_valid) begin
      pulse_cnt++;
      last_w = bus.user_data_out;
      last_s = bus.sat;
      pulse_q.push_back(cyc);
    end
  end

  task automatic step(bit v, bit s, int re, int im);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din_re    = DATA_W'(re);
    bus.din_im    = DATA_W'(im);
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd_comp();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int s_cyc;
    int n;

    user_rst_n = 1'b0;
    bus.win_len = LEN_W'($urandom);
    bus.din_valid = 1'b0;
    bus.sync = 1'b0;
    bus.din_re = '0;
    bus.din_im = '0;

    // Reset with random activity, then release with no valid
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), rnd_comp(), rnd_comp());
    user_rst_n = 1'b1;
    idle(4);
    chk("post_reset_pulses", 32'(pulse_cnt), 32'd0);

    // 4 samples of (3,4) after a sync -> 100, latency 3
    bus.win_len = LEN_W'(4);
    step(1'b0, 1'b1, 0, 0);
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3, 4);
    s_cyc = cyc;
    idle(6);
    chk("t1_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("t1_latency", 32'(pulse_q[$] - s_cyc), 32'd3);
    chk("t1_word", lo(last_w), 32'd100);
    chk("t1_sat", 32'(last_s), 32'd0);
    chk("t1_model_pin", lo(held_w), 32'd100);

    // 12 contiguous samples of (1,1) -> three windows of 8, 4 cycles apart
    p0 = pulse_cnt;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1, 1);
    idle(6);
    chk("t2_pulses", 32'(pulse_cnt - p0), 32'd3);
    n = pulse_q.size();
    chk("t2_gap_a", 32'(pulse_q[n-1] - pulse_q[n-2]), 32'd4);
    chk("t2_gap_b", 32'(pulse_q[n-2] - pulse_q[n-3]), 32'd4);
    chk("t2_word", lo(last_w), 32'd8);

    // sync mid-window discards the partial window; sync sample opens the next
    bus.win_len = LEN_W'(3);
    p0 = pulse_cnt;
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b1, 2, 0);
    step(1'b1, 1'b0, 2, 0);
    step(1'b1, 1'b0, 2, 0);
    idle(6);
    chk("t3_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("t3_word", lo(last_w), 32'd12);

    // Saturating single-sample window, then a tiny one
    bus.win_len = LEN_W'(1);
    step(1'b1, 1'b0, -131072, -131072);
    idle(5);
`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
    chk("t4_word_sat", lo(last_w), 32'h00FF_FFFF);
`else
    chk("t4_word_sat", lo(last_w), 32'hFFFF_FFFF);
`endif
    chk("t4_sat", 32'(last_s), 32'd1);
    step(1'b1, 1'b0, 1, 0);
    idle(5);
    chk("t4_word_small", lo(last_w), 32'd1);
    chk("t4_sat_clear", 32'(last_s), 32'd0);

    // win_len = 0 behaves as a single-sample window
    bus.win_len = LEN_W'(0);
    step(1'b1, 1'b0, 5, 5);
    idle(5);
    chk("t5_word", lo(last_w), 32'd50);

    // Reset while a closed window is still in the pipeline: nothing published
    bus.win_len = LEN_W'(2);
    p0 = pulse_cnt;
    step(1'b1, 1'b0, 7, 7);
    step(1'b1, 1'b0, 7, 7);
    user_rst_n = 1'b0;
    idle(3);
    user_rst_n = 1'b1;
    idle(6);
    chk("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // 300 single-sample windows from reset; tag of the last one wraps to 0x2B
    user_rst_n = 1'b0;
    idle(2);
    user_rst_n = 1'b1;
    bus.win_len = LEN_W'(1);
    p0 = pulse_cnt;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1, 0);
    idle(6);
    chk("t7_pulses", 32'(pulse_cnt - p0), 32'd300);
`ifdef WINDOW_POWER_CAPTURE_SEQ_TAG_EN
    chk("t7_word", last_w, 32'h2B00_0001);
`else
    chk("t7_word", last_w, 32'h0000_0001);
`endif

    // Randomized traffic: gaps, syncs, win_len changes, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) bus.win_len = LEN_W'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) begin
        user_rst_n = 1'b0;
        idle(2);
        user_rst_n = 1'b1;
      end
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0), rnd_comp(), rnd_comp());
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_power_capture.md
Name: window_power_capture

Overview:
- Upstream feeder for the pol2 window1 dout software register.
- Runs in the user_clk domain. Consumes the streaming complex output of the window stage.
- Accumulates |x|^2 over a software-programmable window length.
- Presents each window's result as a stable 32-bit word, which drives the register's user_data_in, plus a one-cycle update strobe.

Parameters:
- DATA_W, 18, width of each signed two's-complement I/Q input component.
- LEN_W, 16, width of the window-length input; the maximum window is 2^LEN_W-1 samples.

Ports:
- user_clk  input  1  design clock; all logic is on the rising edge.
- user_rst_n  input  1  asynchronous active-low reset.
- din_re  input  DATA_W  signed real sample.
- din_im  input  DATA_W  signed imaginary sample.
- din_valid  input  1  sample qualifier.
- sync  input  1  window restart pulse.
- win_len  input  LEN_W  window length in samples, static from software.
- user_data_out  output  32  latched window power; connects to the register's user_data_in.
- dout_valid  output  1  one-cycle pulse when user_data_out updates.
- sat  output  1  last published window saturated.

Behaviour:
- Reset (async assert, sync release): user_data_out=0, dout_valid=0, sat=0. Pipeline registers, accumulator and sample counter are all 0.
- Stage 1 (registered):
  - p = re*re + im*im, unsigned, 2*DATA_W+1 bits, exact.
  - din_valid and sync are registered alongside as v1 and s1.
- Stage 2 (accumulate), when v1 or s1:
  - If s1: acc = (v1 ? p : 0), cnt = (v1 ? 1 : 0), ovf = 0. The previous partial window is discarded and never published.
  - Else if v1: acc = acc + p, cnt = cnt + 1.
  - Accumulator width is 2*DATA_W+1+LEN_W. It cannot wrap.
- Window close, with L = (win_len==0 ? 1 : win_len):
  - Occurs on the stage-2 cycle where v1=1 and the post-increment cnt equals L.
  - On the next edge: user_data_out = min(acc_new, 32'hFFFF_FFFF), sat = (acc_new > 32'hFFFF_FFFF), dout_valid=1 for exactly one cycle.
  - On the same edge acc and cnt clear to 0.
- Latency: dout_valid asserts 3 user_clk edges after the edge that samples the window's last din_valid.
- user_data_out and sat hold between updates and are never cleared by sync.
- Simultaneous sync and valid: the sample is the first sample of the new window.
- sync with L=1 and valid: that sample closes a window immediately.
- win_len change mid-window: the compare uses the current win_len. If cnt is already >= the new L, the window closes at the next valid sample.
- Back-to-back windows need no gap cycles. A sample arriving in the close cycle starts the next window.
- din_valid low: the pipeline advances and the accumulator holds.
- Reset mid-window: all state is lost and no dout_valid is produced.

Optional Feature:
- Macro: WINDOW_POWER_CAPTURE_SEQ_TAG_EN.
- When defined:
  - An 8-bit window sequence counter increments on each published window and wraps 255->0. It resets to 0 only on user_rst_n.
  - user_data_out[31:24] = sequence value of this window.
  - user_data_out[23:0] = min(acc, 24'hFFFFFF).
  - sat reflects the 24-bit saturation.
- When undefined: full 32-bit power as described above; no sequence counter logic.

Test Plan:
- Reset: hold user_rst_n=0 with random inputs -> user_data_out=0, dout_valid=0, sat=0. Release with no valid -> outputs unchanged.
- win_len=4, sync, then 4 valid samples (3,4) -> one dout_valid 3 edges after the last sample, user_data_out=100, sat=0.
- win_len=4, 12 contiguous valid samples (1,1) with no gaps -> three dout_valid pulses 4 cycles apart, each with user_data_out=8.
- win_len=3, 2 valid samples (10,0), then sync together with valid (2,0), then 2 more (2,0) -> the partial window is not published; next output=12.
- win_len=1, valid (-131072,-131072) -> user_data_out=32'hFFFF_FFFF, sat=1. Next sample (1,0) -> user_data_out=1, sat=0.
- win_len=0, valid (5,5) -> treated as L=1: user_data_out=50. With SEQ_TAG_EN, 300 windows of (1,0) at L=1 -> 300th word = 32'h2B00_0001.
